// File: rtl/radar_target_emulator.sv
// Radar target emulator: answers each radar trigger edge with an echo pulse delayed by the programmed range.
// Latency: edge sampled at posedge T, echo rises at posedge T+N, where N = max(1, ceil(range/METERS_PER_CYCLE)).
// Backpressure: none; trigger edges arriving while a round trip is in progress are dropped and counted.
module radar_target_emulator #(
  parameter int unsigned METERS_PER_CYCLE = 15000,
  parameter int unsigned MAX_RANGE        = 600000,
  parameter int unsigned ECHO_WIDTH       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        radar_pulse_trigger,
  input  logic        load_target,
  input  logic [31:0] target_range_in,
  input  logic [15:0] closing_step,
  input  logic        target_present,
  output logic        radar_echo,
  output logic        busy,
  output logic [15:0] pulse_count,
  output logic [7:0]  dropped_triggers,
  output logic [31:0] current_range
);

  localparam int WCW = (ECHO_WIDTH > 1) ? $clog2(ECHO_WIDTH) : 1;
  localparam logic [WCW-1:0] WIDTH_LAST = WCW'(ECHO_WIDTH - 1);
  localparam logic [32:0]    STEP       = 33'(METERS_PER_CYCLE);
  localparam logic [31:0]    MAX_R      = 32'(MAX_RANGE);

  typedef enum logic [1:0] {IDLE, FLIGHT, ECHO} state_t;

  state_t          state;
  logic            trig_d;
  logic [32:0]     acc;
  logic [31:0]     flight_range;
  logic [31:0]     range_reg;
  logic [WCW-1:0]  width_cnt;

  logic            trig_edge;
  logic            echo_last;
  logic [32:0]     acc_next;
  logic [31:0]     closed_range;

  // A held-high trigger produces exactly one edge.
  assign trig_edge = radar_pulse_trigger & ~trig_d;
  // 33-bit accumulator so the sum can never wrap below flight_range.
  assign acc_next = acc + STEP;
  assign echo_last = (state == ECHO) && (width_cnt == WIDTH_LAST);
  // Approaching target: range shrinks by closing_step per echo, clamped at zero.
  assign closed_range = (range_reg > {16'd0, closing_step}) ? (range_reg - {16'd0, closing_step}) : '0;
  assign current_range = range_reg;

  // Trigger history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_d <= 1'b0;
    end else begin
      trig_d <= radar_pulse_trigger;
    end
  end

  // Round-trip FSM: flight range is captured at the edge so later loads do not disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      flight_range <= '0;
      width_cnt    <= '0;
      radar_echo   <= 1'b0;
      busy         <= 1'b0;
      pulse_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          radar_echo <= 1'b0;
          busy       <= 1'b0;
          if (trig_edge && target_present && (range_reg <= MAX_R)) begin
            flight_range <= range_reg;
            acc          <= '0;
            state        <= FLIGHT;
            busy         <= 1'b1;
          end
        end
        FLIGHT: begin
          acc <= acc_next;
          if (acc_next >= {1'b0, flight_range}) begin
            state      <= ECHO;
            radar_echo <= 1'b1;
            width_cnt  <= '0;
          end
        end
        ECHO: begin
          if (width_cnt == WIDTH_LAST) begin
            radar_echo  <= 1'b0;
            busy        <= 1'b0;
            pulse_count <= pulse_count + 16'd1;
            state       <= IDLE;
          end else begin
            width_cnt <= width_cnt + WCW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          radar_echo <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Programmed range: an explicit load takes priority over the per-echo closing update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_reg <= '0;
    end else if (load_target) begin
      range_reg <= target_range_in;
    end else if (echo_last) begin
      range_reg <= closed_range;
    end
  end

  // Count trigger edges that arrive while a round trip is in progress, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_triggers <= '0;
    end else if (trig_edge && (state != IDLE) && (dropped_triggers != 8'hFF)) begin
      dropped_triggers <= dropped_triggers + 8'd1;
    end
  end

endmodule
